// File: rtl/sdram_fifo_traffic_gen.sv
// Write/read/check traffic engine for the SDRAM FIFO user ports.
// Writes a paced pattern burst, reads it back and counts mismatches.
module sdram_fifo_traffic_gen #(
  parameter int          DATA_W     = 16,
  parameter int          BURST_LEN  = 10,
  parameter int          CNT_W      = 10,
  parameter int          WR_GAP     = 7,
  parameter int          NUM_PASSES = 1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1,
  parameter int          TIMEOUT_W  = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              wr_fifo_wr_req,
  output logic [DATA_W-1:0] wr_fifo_wr_data,
  output logic              rd_fifo_rd_req,
  input  logic [DATA_W-1:0] rd_fifo_rd_data,
  input  logic [CNT_W-1:0]  rd_fifo_num,
  output logic              read_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic [DATA_W-1:0] err_first_exp,
  output logic [DATA_W-1:0] err_first_got
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_WR, S_RD_WAIT,
    S_RD, S_RD_LAST, S_PASS_END, S_DONE
  } state_e;

  function automatic logic [31:0] tap(int n);
    return (n > 0) ? (32'd1 << (n - 1)) : 32'd0;
  endfunction

  // Maximal-length Fibonacci feedback taps per width.
  function automatic logic [31:0] tap_mask(int w);
    case (w)
      8:  return tap(8) | tap(6) | tap(5) | tap(4);
      9:  return tap(9) | tap(5);
      10: return tap(10) | tap(7);
      11: return tap(11) | tap(9);
      12: return tap(12) | tap(6) | tap(4) | tap(1);
      13: return tap(13) | tap(4) | tap(3) | tap(1);
      14: return tap(14) | tap(5) | tap(3) | tap(1);
      15: return tap(15) | tap(14);
      16: return tap(16) | tap(14) | tap(13) | tap(11);
      17: return tap(17) | tap(14);
      18: return tap(18) | tap(11);
      19: return tap(19) | tap(6) | tap(2) | tap(1);
      20: return tap(20) | tap(17);
      21: return tap(21) | tap(19);
      22: return tap(22) | tap(21);
      23: return tap(23) | tap(18);
      24: return tap(24) | tap(23) | tap(22) | tap(17);
      25: return tap(25) | tap(22);
      26: return tap(26) | tap(6) | tap(2) | tap(1);
      27: return tap(27) | tap(5) | tap(2) | tap(1);
      28: return tap(28) | tap(25);
      29: return tap(29) | tap(27);
      30: return tap(30) | tap(6) | tap(4) | tap(1);
      31: return tap(31) | tap(28);
      32: return tap(32) | tap(22) | tap(2) | tap(1);
      default: return tap(w) | tap(w - 1);
    endcase
  endfunction

  localparam logic [DATA_W-1:0] TAPS  = DATA_W'(tap_mask(DATA_W));
  localparam logic [DATA_W-1:0] SEED  = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] ONES  = '1;
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);
  localparam logic [CNT_W-1:0]  BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [15:0] GAP_LAST =
    16'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [16:0] NP = 17'(NUM_PASSES);
  localparam state_e S_FIRST = (WR_GAP == 0) ? S_WR : S_GAP;

  function automatic logic [DATA_W-1:0] gen_init(logic [1:0] m);
    case (m)
      2'd0:    return '0;
      2'd1:    return ONE;
      2'd2:    return SEED;
      default: return ONES;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] gen_next(
    logic [1:0] m, logic [DATA_W-1:0] v);
    case (m)
      2'd0:    return v + ONE;
      2'd1:    return {v[DATA_W-2:0], v[DATA_W-1]};
      2'd2:    return {v[DATA_W-2:0], ^(v & TAPS)};
      default: return ~v;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic                  start_q;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           gap_q, gap_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic [DATA_W-1:0]     wgen_q, wgen_d;
  logic [DATA_W-1:0]     cgen_q, cgen_d;
  logic                  chk_q, chk_d;
  logic                  rv_q, rv_d;
  logic [15:0]           pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [DATA_W-1:0]     fexp_q, fexp_d;
  logic [DATA_W-1:0]     fgot_q, fgot_d;
  logic                  start_rise;
  logic                  last_pass;

  assign start_rise = start & ~start_q;
  assign last_pass  = (NUM_PASSES != 0)
                    ? (({1'b0, pass_q} + 17'd1) == NP)
                    : ~start;

  assign wr_fifo_wr_req  = (state_q == S_WR);
  assign wr_fifo_wr_data = wgen_q;
  assign rd_fifo_rd_req  = (state_q == S_RD);
  assign read_valid      = rv_q;
  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign pass_cnt        = pass_q;
  assign err_cnt         = err_q;
  assign err_first_exp   = fexp_q;
  assign err_first_got   = fgot_q;

  // Next-state, pattern generators, checker and error capture.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wait_d  = wait_q;
    wgen_d  = wgen_q;
    cgen_d  = cgen_q;
    chk_d   = (state_q == S_RD);
    rv_d    = rv_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;

    if (chk_q) begin
      cgen_d = gen_next(mode_q, cgen_q);
      if (rd_fifo_rd_data != cgen_q) begin
        if (err_q == 16'd0) begin
          fexp_d = cgen_q;
          fgot_d = rd_fifo_rd_data;
        end
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          mode_d  = mode;
          pass_d  = '0;
          err_d   = '0;
          fexp_d  = '0;
          fgot_d  = '0;
          wgen_d  = gen_init(mode);
          cgen_d  = gen_init(mode);
          gap_d   = '0;
          wcnt_d  = '0;
          rcnt_d  = '0;
          state_d = S_FIRST;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_WR;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_WR: begin
        wgen_d = gen_next(mode_q, wgen_q);
        if (wcnt_q == LAST) begin
          wcnt_d  = '0;
          wait_d  = '0;
          rv_d    = 1'b0;
          state_d = S_RD_WAIT;
        end else begin
          wcnt_d  = wcnt_q + CNT_W'(1);
          state_d = S_FIRST;
        end
      end
      S_RD_WAIT: begin
        if (rd_fifo_num >= BURST) begin
          wait_d  = '0;
          state_d = S_RD;
        end else if (&wait_q) begin
          if (err_q == 16'd0) begin
            fexp_d = DATA_W'(BURST_LEN);
            fgot_d = DATA_W'(rd_fifo_num);
          end
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      S_RD: begin
        if (rcnt_q == LAST) begin
          rcnt_d  = '0;
          state_d = S_RD_LAST;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      S_RD_LAST: state_d = S_PASS_END;
      S_PASS_END: begin
        if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
        wgen_d  = gen_init(mode_q);
        cgen_d  = gen_init(mode_q);
        state_d = last_pass ? S_DONE : S_FIRST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      mode_q  <= '0;
      gap_q   <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wait_q  <= '0;
      wgen_q  <= '0;
      cgen_q  <= '0;
      chk_q   <= 1'b0;
      rv_q    <= 1'b1;
      pass_q  <= '0;
      err_q   <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wait_q  <= wait_d;
      wgen_q  <= wgen_d;
      cgen_q  <= cgen_d;
      chk_q   <= chk_d;
      rv_q    <= rv_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

endmodule

// File: tb/tb_sdram_fifo_traffic_gen.sv
// Bench for sdram_fifo_traffic_gen: paced single pass (a) and
// back-to-back 8-bit three-pass engine (b), each on a loopback FIFO.
module tb_sdram_fifo_traffic_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int failed = 0;
  int cyc = 0;

  logic        a_start = 1'b0;
  logic [1:0]  a_mode = 2'd0;
  logic        a_wr_req, a_rd_req, a_rv, a_busy, a_done;
  logic [15:0] a_wr_data, a_rd_data;
  logic [9:0]  a_num;
  logic [15:0] a_pass, a_err, a_fexp, a_fgot;

  logic        b_start = 1'b0;
  logic [1:0]  b_mode = 2'd0;
  logic        b_wr_req, b_rd_req, b_rv, b_busy, b_done;
  logic [7:0]  b_wr_data, b_rd_data;
  logic [9:0]  b_num;
  logic [15:0] b_pass, b_err;
  logic [7:0]  b_fexp, b_fgot;

  sdram_fifo_traffic_gen #(
    .DATA_W(16), .BURST_LEN(10), .CNT_W(10), .WR_GAP(7),
    .NUM_PASSES(1), .LFSR_SEED(32'hACE1), .TIMEOUT_W(12)
  ) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(a_start),
    .mode(a_mode), .wr_fifo_wr_req(a_wr_req),
    .wr_fifo_wr_data(a_wr_data), .rd_fifo_rd_req(a_rd_req),
    .rd_fifo_rd_data(a_rd_data), .rd_fifo_num(a_num),
    .read_valid(a_rv), .busy(a_busy), .done(a_done),
    .pass_cnt(a_pass), .err_cnt(a_err),
    .err_first_exp(a_fexp), .err_first_got(a_fgot)
  );

  sdram_fifo_traffic_gen #(
    .DATA_W(8), .BURST_LEN(10), .CNT_W(10), .WR_GAP(0),
    .NUM_PASSES(3), .LFSR_SEED(32'hACE1), .TIMEOUT_W(12)
  ) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(b_start),
    .mode(b_mode), .wr_fifo_wr_req(b_wr_req),
    .wr_fifo_wr_data(b_wr_data), .rd_fifo_rd_req(b_rd_req),
    .rd_fifo_rd_data(b_rd_data), .rd_fifo_num(b_num),
    .read_valid(b_rv), .busy(b_busy), .done(b_done),
    .pass_cnt(b_pass), .err_cnt(b_err),
    .err_first_exp(b_fexp), .err_first_got(b_fgot)
  );

  // Loopback FIFO models (data readable the cycle after a read strobe).
  logic [15:0] aq[$];
  logic [7:0]  bq[$];
  int a_ridx = 0;
  int a_corrupt = -1;
  bit a_stuck = 1'b0;

  always @(posedge clk) begin
    logic [15:0] d;
    if (!rst_n) begin
      aq.delete();
      a_ridx = 0;
      a_rd_data <= '0;
      a_num <= '0;
    end else begin
      if (a_wr_req) aq.push_back(a_wr_data);
      if (a_rd_req) begin
        d = (aq.size() > 0) ? aq.pop_front() : 16'h0;
        if (a_ridx == a_corrupt) d = 16'h0;
        a_ridx++;
        a_rd_data <= d;
      end
      if (a_stuck && aq.size() > 9) a_num <= 10'd9;
      else a_num <= 10'(aq.size());
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      bq.delete();
      b_rd_data <= '0;
      b_num <= '0;
    end else begin
      if (b_wr_req) bq.push_back(b_wr_data);
      if (b_rd_req && bq.size() > 0) b_rd_data <= bq.pop_front();
      b_num <= 10'(bq.size());
    end
  end

  // Strobe logs, sampled mid-cycle.
  logic [15:0] a_wlog[$];
  int          a_wcyc[$];
  int          a_rcyc[$];
  int          a_both = 0;
  bit          a_rv_prev = 1'b1;
  int          a_rv_fall = -1;
  logic [7:0]  b_wlog[$];
  int          b_wcyc[$];
  int          b_both = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      a_wlog.delete();
      a_wcyc.delete();
      a_rcyc.delete();
      a_both = 0;
      a_rv_prev = 1'b1;
      a_rv_fall = -1;
      b_wlog.delete();
      b_wcyc.delete();
      b_both = 0;
    end else begin
      if (a_wr_req) begin
        a_wlog.push_back(a_wr_data);
        a_wcyc.push_back(cyc);
      end
      if (a_rd_req) a_rcyc.push_back(cyc);
      if (a_wr_req && a_rd_req) a_both++;
      if (a_rv_prev && !a_rv && a_rv_fall < 0) a_rv_fall = cyc;
      a_rv_prev = a_rv;
      if (b_wr_req) begin
        b_wlog.push_back(b_wr_data);
        b_wcyc.push_back(cyc);
      end
      if (b_wr_req && b_rd_req) b_both++;
    end
  end

  // Reference pattern: word idx of a pass for width w and mode m.
  function automatic logic [31:0] exp_word(
    input int w, input int m, input int idx);
    logic [31:0] mask, v;
    int taps[4];
    logic fb;
    mask = (32'd1 << w) - 32'd1;
    case (m)
      0: return 32'(idx) & mask;
      1: return 32'd1 << (idx % w);
      3: return (idx % 2 == 0) ? mask : 32'd0;
      default: begin
        if (w == 16) taps = '{16, 14, 13, 11};
        else taps = '{8, 6, 5, 4};
        v = 32'hACE1 & mask;
        for (int k = 0; k < idx; k++) begin
          fb = 1'b0;
          foreach (taps[t]) fb ^= v[taps[t] - 1];
          v = ((v << 1) | 32'(fb)) & mask;
        end
        return v;
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_a(input logic [1:0] m, input int budget);
    int n;
    a_mode = m;
    @(negedge clk);
    a_start = 1'b1;
    repeat (2) @(negedge clk);
    a_start = 1'b0;
    n = 0;
    while (!a_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (a_done !== 1'b1) begin
      failed++;
      $display("FAIL run_a_done: done=%b after %0d cycles, need 1",
               a_done, n);
    end
  endtask

  task automatic run_b(input logic [1:0] m, input int budget);
    int n;
    b_mode = m;
    @(negedge clk);
    b_start = 1'b1;
    repeat (2) @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (b_done !== 1'b1) begin
      failed++;
      $display("FAIL run_b_done: done=%b after %0d cycles, need 1",
               b_done, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({a_wr_req, a_rd_req, a_busy, a_done, a_rv} !== 5'b00001) begin
      failed++;
      $display("FAIL reset_flags: got %b need 00001",
               {a_wr_req, a_rd_req, a_busy, a_done, a_rv});
    end
    compared++;
    if ({a_pass, a_err, a_fexp, a_fgot, a_wr_data} !== 80'd0) begin
      failed++;
      $display("FAIL reset_counters: got %h need 0",
               {a_pass, a_err, a_fexp, a_fgot, a_wr_data});
    end
    compared++;
    if ({b_busy, b_done, b_rv} !== 3'b001) begin
      failed++;
      $display("FAIL reset_b_flags: got %b need 001",
               {b_busy, b_done, b_rv});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mode0_paced();
    int nw, nr;
    do_reset();
    run_a(2'd0, 600);
    nw = a_wlog.size();
    nr = a_rcyc.size();
    compared++;
    if (nw != 10) begin
      failed++;
      $display("FAIL m0_write_count: got %0d need 10", nw);
    end
    for (int i = 0; i < nw && i < 10; i++) begin
      compared++;
      if (32'(a_wlog[i]) !== exp_word(16, 0, i)) begin
        failed++;
        $display("FAIL m0_word%0d: got %h need %h",
                 i, a_wlog[i], exp_word(16, 0, i));
      end
    end
    for (int i = 1; i < nw; i++) begin
      compared++;
      if (a_wcyc[i] - a_wcyc[i-1] != 8) begin
        failed++;
        $display("FAIL m0_spacing%0d: got %0d need 8",
                 i, a_wcyc[i] - a_wcyc[i-1]);
      end
    end
    compared++;
    if (nr != 10 || a_rcyc[nr-1] - a_rcyc[0] != 9) begin
      failed++;
      $display("FAIL m0_read_burst: got %0d strobes, need 10 in a row",
               nr);
    end
    compared++;
    if (nw > 0 && a_rv_fall != a_wcyc[nw-1] + 1) begin
      failed++;
      $display("FAIL m0_read_valid_fall: got cycle %0d need %0d",
               a_rv_fall, a_wcyc[nw-1] + 1);
    end
    compared++;
    if ({a_pass, a_err, a_rv, a_busy} !== {16'd1, 16'd0, 2'b00}) begin
      failed++;
      $display("FAIL m0_status: pass=%0d err=%0d rv=%b busy=%b, need 1 0 0 0",
               a_pass, a_err, a_rv, a_busy);
    end
    compared++;
    if (a_both != 0) begin
      failed++;
      $display("FAIL m0_strobe_overlap: got %0d need 0", a_both);
    end
  endtask

  task automatic test_lfsr_seed();
    do_reset();
    run_a(2'd2, 600);
    compared++;
    if (a_wlog.size() < 1 || a_wlog[0] !== 16'hACE1) begin
      failed++;
      $display("FAIL lfsr_first_word: got %h need ace1",
               (a_wlog.size() > 0) ? a_wlog[0] : 16'hx);
    end
    for (int i = 1; i < a_wlog.size() && i < 10; i++) begin
      compared++;
      if (32'(a_wlog[i]) !== exp_word(16, 2, i)) begin
        failed++;
        $display("FAIL lfsr_word%0d: got %h need %h",
                 i, a_wlog[i], exp_word(16, 2, i));
      end
    end
    compared++;
    if (a_err !== 16'd0) begin
      failed++;
      $display("FAIL lfsr_err_cnt: got %0d need 0", a_err);
    end
  endtask

  task automatic test_alt_pattern();
    do_reset();
    run_a(2'd3, 600);
    for (int i = 0; i < a_wlog.size() && i < 10; i++) begin
      compared++;
      if (32'(a_wlog[i]) !== exp_word(16, 3, i)) begin
        failed++;
        $display("FAIL alt_word%0d: got %h need %h",
                 i, a_wlog[i], exp_word(16, 3, i));
      end
    end
    compared++;
    if ({a_pass, a_err} !== {16'd1, 16'd0}) begin
      failed++;
      $display("FAIL alt_status: pass=%0d err=%0d need 1 0",
               a_pass, a_err);
    end
  endtask

  task automatic test_corrupt();
    a_corrupt = 4;
    do_reset();
    run_a(2'd0, 600);
    compared++;
    if ({a_err, a_fexp, a_fgot} !== {16'd1, 16'h0004, 16'h0000}) begin
      failed++;
      $display("FAIL corrupt_capture: err=%0d exp=%h got=%h need 1 0004 0000",
               a_err, a_fexp, a_fgot);
    end
    a_corrupt = -1;
  endtask

  task automatic test_timeout();
    a_stuck = 1'b1;
    do_reset();
    run_a(2'd0, 6000);
    compared++;
    if ({a_err, a_fexp, a_fgot} !== {16'd1, 16'd10, 16'd9}) begin
      failed++;
      $display("FAIL timeout_capture: err=%0d exp=%0d got=%0d need 1 10 9",
               a_err, a_fexp, a_fgot);
    end
    compared++;
    if (a_rcyc.size() != 0 || a_pass !== 16'd0) begin
      failed++;
      $display("FAIL timeout_no_reads: reads=%0d pass=%0d need 0 0",
               a_rcyc.size(), a_pass);
    end
    a_stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nw;
    do_reset();
    run_b(2'd2, 1000);
    nw = b_wlog.size();
    compared++;
    if (nw != 30) begin
      failed++;
      $display("FAIL b2b_write_count: got %0d need 30", nw);
    end
    for (int i = 0; i < nw && i < 30; i++) begin
      compared++;
      if (32'(b_wlog[i]) !== exp_word(8, 2, i % 10)) begin
        failed++;
        $display("FAIL b2b_word%0d: got %h need %h",
                 i, b_wlog[i], exp_word(8, 2, i % 10));
      end
      if (i % 10 != 0) begin
        compared++;
        if (b_wcyc[i] - b_wcyc[i-1] != 1) begin
          failed++;
          $display("FAIL b2b_spacing%0d: got %0d need 1",
                   i, b_wcyc[i] - b_wcyc[i-1]);
        end
      end
    end
    compared++;
    if ({b_pass, b_err} !== {16'd3, 16'd0} || b_both != 0) begin
      failed++;
      $display("FAIL b2b_status: pass=%0d err=%0d overlap=%0d need 3 0 0",
               b_pass, b_err, b_both);
    end
  endtask

  task automatic test_walk_one_busy_start();
    int n;
    do_reset();
    b_mode = 2'd1;
    @(negedge clk);
    b_start = 1'b1;
    repeat (2) @(negedge clk);
    b_start = 1'b0;
    repeat (12) @(negedge clk);
    compared++;
    if (b_busy !== 1'b1) begin
      failed++;
      $display("FAIL walk_busy: got %b need 1", b_busy);
    end
    b_mode = 2'd3;
    b_start = 1'b1;
    repeat (2) @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!b_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    compared++;
    if (b_wlog.size() != 30 || b_done !== 1'b1) begin
      failed++;
      $display("FAIL walk_single_run: writes=%0d done=%b need 30 1",
               b_wlog.size(), b_done);
    end
    for (int i = 0; i < b_wlog.size() && i < 30; i++) begin
      compared++;
      if (32'(b_wlog[i]) !== exp_word(8, 1, i % 10)) begin
        failed++;
        $display("FAIL walk_word%0d: got %h need %h",
                 i, b_wlog[i], exp_word(8, 1, i % 10));
      end
    end
    compared++;
    if ({b_pass, b_err} !== {16'd3, 16'd0}) begin
      failed++;
      $display("FAIL walk_status: pass=%0d err=%0d need 3 0",
               b_pass, b_err);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    do_reset();
    b_mode = 2'd0;
    @(negedge clk);
    b_start = 1'b1;
    repeat (2) @(negedge clk);
    b_start = 1'b0;
    n = 0;
    k = 0;
    while (k < 5 && n < 2000) begin
      @(negedge clk);
      n++;
      if (b_wr_req && b_pass == 16'd1) k++;
    end
    compared++;
    if (k != 5) begin
      failed++;
      $display("FAIL mid_reach_write: got %0d writes need 5", k);
    end
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({b_wr_req, b_rd_req, b_busy, b_done, b_rv} !== 5'b00001) begin
      failed++;
      $display("FAIL mid_reset_flags: got %b need 00001",
               {b_wr_req, b_rd_req, b_busy, b_done, b_rv});
    end
    compared++;
    if ({b_pass, b_err, b_fexp, b_fgot, b_wr_data} !== 56'd0) begin
      failed++;
      $display("FAIL mid_reset_counters: got %h need 0",
               {b_pass, b_err, b_fexp, b_fgot, b_wr_data});
    end
    rst_n = 1'b1;
    run_b(2'd0, 1000);
    compared++;
    if ({b_pass, b_err} !== {16'd3, 16'd0} || b_wlog.size() != 30) begin
      failed++;
      $display("FAIL mid_restart: pass=%0d err=%0d writes=%0d need 3 0 30",
               b_pass, b_err, b_wlog.size());
    end
  endtask

  initial begin
    test_reset();
    test_mode0_paced();
    test_lfsr_seed();
    test_alt_pattern();
    test_corrupt();
    test_timeout();
    test_back_to_back();
    test_walk_one_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule

// File: doc/sdram_fifo_traffic_gen.md
Name: sdram_fifo_traffic_gen

Overview:
Parametrised write/read/check traffic engine for the SDRAM FIFO controller (sdram_top) user ports. It writes BURST_LEN pattern words into the write FIFO at a programmable pace. It then waits until the read FIFO holds the full burst, reads it back and compares each word against the regenerated pattern. It runs NUM_PASSES passes and reports done, error count and first-error data; it serves both as a board self-test and as a bench stimulus/checker.

Parameters:
DATA_W, 16, FIFO data width in bits (8..32)
BURST_LEN, 10, words per pass; also the rd_fifo_num threshold
CNT_W, 10, width of rd_fifo_num and the word counters; BURST_LEN < 2^CNT_W
WR_GAP, 7, idle cycles between consecutive write requests (0 = back-to-back)
NUM_PASSES, 1, passes per start; 0 = run until start deasserted
LFSR_SEED, 16'hACE1, nonzero seed for pattern mode 2 (truncated/zero-extended to DATA_W)

Ports:
sys_clk  in  1  single clock; also the FIFO user-side clock
sys_rst_n  in  1  synchronous active-low reset
start  in  1  level; rising edge seen in IDLE/DONE begins a run
mode  in  2  pattern: 0 increment from 0, 1 walking-one, 2 Fibonacci LFSR, 3 all-ones/all-zeros alternate; sampled at start
wr_fifo_wr_req  out  1  write strobe, one word per cycle high
wr_fifo_wr_data  out  DATA_W  word written, valid with wr_fifo_wr_req
rd_fifo_rd_req  out  1  read strobe
rd_fifo_rd_data  in  DATA_W  read data, valid the cycle after rd_fifo_rd_req (normal-mode FIFO)
rd_fifo_num  in  CNT_W  words currently in the read FIFO
read_valid  out  1  enables controller read-back; high from reset until the first write burst completes, low thereafter
busy  out  1  high in any state other than IDLE/DONE
done  out  1  high in DONE
pass_cnt  out  16  completed passes, saturating
err_cnt  out  16  mismatched words, saturating at 16'hFFFF
err_first_exp  out  DATA_W  expected word of the first mismatch
err_first_got  out  DATA_W  received word of the first mismatch

Behaviour:
- Reset (sys_rst_n=0 at posedge): state IDLE; all outputs 0 except read_valid=1. Reset mid-run aborts immediately; no further strobes are issued.
- States: IDLE -> WR_GAP_ST -> WR -> (loop) -> RD_WAIT -> RD -> RD_LAST -> PASS_END -> WR_GAP_ST or DONE.
- IDLE/DONE: on start rising edge (registered edge detect), latch mode, clear pass_cnt/err_cnt/err_first_*, reset both pattern generators, go to WR_GAP_ST.
- WR_GAP_ST: gap counter counts WR_GAP cycles, then WR. When WR_GAP=0, go straight to WR.
- WR: assert wr_fifo_wr_req for exactly one cycle with the current pattern word and advance the generator. After word BURST_LEN-1 go to RD_WAIT; otherwise return to WR_GAP_ST.
- Write pacing: with WR_GAP=7, strobes are 8 cycles apart.
- read_valid drops to 0 the cycle after the last write of pass 0 and stays 0 until reset.
- RD_WAIT: wait until rd_fifo_num >= BURST_LEN, then RD. A wait longer than 2^20 cycles counts as one error; set err_first_exp = BURST_LEN, err_first_got = rd_fifo_num (zero-extended to DATA_W); go to DONE.
- RD: assert rd_fifo_rd_req for BURST_LEN consecutive cycles. The check generator (same algorithm, reset per pass) compares rd_fifo_rd_data one cycle after each strobe.
- RD_LAST: one cycle to check the final word. Then PASS_END increments pass_cnt.
- Mismatch: increment err_cnt (saturating). On the first mismatch only (err_cnt was 0), capture err_first_exp and err_first_got.
- Patterns:
  - mode 0: wraps modulo 2^DATA_W.
  - mode 1: starts at 1 and rotates left; the MSB wraps to bit 0.
  - mode 2: maximal-length LFSR, taps 16,14,13,11 for DATA_W=16; shifts once per word.
  - mode 3: starts at all-ones.
- PASS_END: go to DONE when pass_cnt+1 == NUM_PASSES (NUM_PASSES≠0), or when NUM_PASSES=0 and start is low; otherwise WR_GAP_ST. Generators restart per pass, so every pass writes identical data.
- Simultaneous events: start is ignored while busy. wr_fifo_wr_req and rd_fifo_rd_req are never high together.

Test Plan:
- Defaults, mode 0, loopback FIFO model: 10 writes of 0..9, strobes 8 cycles apart -> rd_en for 10 cycles, done=1, pass_cnt=1, err_cnt=0, read_valid fell after the 10th write.
- Mode 2, NUM_PASSES=3, WR_GAP=0: 10 back-to-back writes per pass; first word 16'hACE1; identical sequences each pass -> pass_cnt=3, err_cnt=0.
- Model corrupts word 4 to 16'h0000 (mode 0) -> err_cnt=1, err_first_exp=16'h0004, err_first_got=16'h0000.
- Model stuck at rd_fifo_num=9 -> after 2^20 cycles done=1, err_cnt=1, err_first_exp=10, err_first_got=9, no rd_fifo_rd_req ever asserted.
- Reset asserted at the 5th write of pass 1 -> next cycle all strobes 0, busy=0, read_valid=1, counters 0; a restart runs clean.
- Mode 1, DATA_W=8, BURST_LEN=10 -> writes 01,02,04,…,80,01,02; start pulsed while busy is ignored.
